// File: rtl/exc_ctrl_if.sv
// Signal bundle between the decoder/hazard side and the trap sequencer.
// The master drives the decoded trap flags; the slave returns pipeline controls and trap state.
interface exc_ctrl_if;
    logic        id_valid;
    logic        id_stall;
    logic        siic;
    logic        rti;
    logic        err;
    logic        halt;
    logic [15:0] id_pc_inc;
    logic        flush_if_id;
    logic        freeze;
    logic        bubble;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        halted;
    logic        busy;

    modport master (
        output id_valid, id_stall, siic, rti, err, halt, id_pc_inc,
        input  flush_if_id, freeze, bubble, pc_redirect, pc_target,
               epc, cause, halted, busy
    );

    modport slave (
        input  id_valid, id_stall, siic, rti, err, halt, id_pc_inc,
        output flush_if_id, freeze, bubble, pc_redirect, pc_target,
               epc, cause, halted, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Trap sequencer for SIIC / RTI / illegal opcode / HALT.
// It flushes the younger instruction, drains older ones, then redirects the PC or parks the core.
module exc_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [15:0] SIIC_ADDR    = 16'h0002,
    parameter logic [15:0] ERR_ADDR     = 16'h0002
) (
    input  logic       clk,
    input  logic       rst_n,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT, HALTED} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  count_reg;
    logic [15:0] epc_reg;
    logic [15:0] target_reg;
    logic [1:0]  cause_reg;
    logic        accept;

    assign accept = (state_reg == IDLE) & bus.id_valid & ~bus.id_stall &
                    (bus.siic | bus.rti | bus.err | bus.halt);

    // State register plus the trap datapath it owns; flag priority is halt > err > siic > rti.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            count_reg  <= 3'd0;
            epc_reg    <= 16'h0000;
            target_reg <= 16'h0000;
            cause_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        count_reg <= 3'(DRAIN_CYCLES - 1);
                        if (bus.halt) begin
                            cause_reg <= 2'b11;
                        end else if (bus.err) begin
                            epc_reg    <= bus.id_pc_inc;
                            cause_reg  <= 2'b10;
                            target_reg <= ERR_ADDR;
                        end else if (bus.siic) begin
                            epc_reg    <= bus.id_pc_inc;
                            cause_reg  <= 2'b01;
                            target_reg <= SIIC_ADDR;
                        end else begin
                            target_reg <= epc_reg;
                        end
                    end
                end
                DRAIN: begin
                    if (count_reg != 3'd0) count_reg <= count_reg - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Only a halt writes cause 11, and HALTED is terminal, so cause alone identifies the halt path.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept) state_next = DRAIN;
            DRAIN:    if (count_reg == 3'd0)
                          state_next = (cause_reg == 2'b11) ? HALTED : REDIRECT;
            REDIRECT: state_next = IDLE;
            HALTED:   state_next = HALTED;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_if_id = 1'b0;
        bus.freeze      = 1'b0;
        bus.bubble      = 1'b0;
        bus.pc_redirect = 1'b0;
        bus.pc_target   = 16'h0000;
        bus.halted      = 1'b0;
        case (state_reg)
            IDLE: bus.flush_if_id = accept;
            DRAIN: begin
                bus.freeze = 1'b1;
                bus.bubble = 1'b1;
            end
            REDIRECT: begin
                bus.pc_redirect = 1'b1;
                bus.pc_target   = target_reg;
                bus.flush_if_id = 1'b1;
                bus.bubble      = 1'b1;
            end
            HALTED: begin
                bus.halted = 1'b1;
                bus.freeze = 1'b1;
                bus.bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.epc   = epc_reg;
    assign bus.cause = cause_reg;
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline sequencer for the trap-class instructions flagged by the decoder: SIIC, RTI, illegal opcode (err) and HALT.
- Sits beside the hazard unit between ID and the PC/fetch logic.
- On acceptance it kills the younger fetched instruction, freezes fetch, bubbles ID/EX while older instructions drain, then redirects the PC (handler, EPC) or parks the core in HALTED.
- Owns the EPC and cause registers.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN so EX/MEM/WB retire older instructions; legal range 1..7.
- SIIC_ADDR, 16'h0002, redirect target for SIIC.
- ERR_ADDR, 16'h0002, redirect target for illegal opcode.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real (non-bubble) instruction
- id_stall  input  1  hazard unit is stalling ID this cycle
- siic  input  1  decoder SIIC flag
- rti  input  1  decoder RTI flag
- err  input  1  decoder illegal-opcode flag
- halt  input  1  decoder Halt flag
- id_pc_inc  input  16  PC+2 of the instruction in ID
- flush_if_id  output  1  invalidate the IF/ID register at the next edge
- freeze  output  1  hold the PC and IF/ID
- bubble  output  1  zero the ID/EX control bits
- pc_redirect  output  1  load pc_target into the PC at the next edge
- pc_target  output  16  redirect address
- epc  output  16  saved return PC
- cause  output  2  last trap: 00 none, 01 SIIC, 10 err, 11 halt
- halted  output  1  core stopped
- busy  output  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, epc 0, cause 00, pending target-select 0. All outputs 0; pc_target 0.
- States: IDLE, DRAIN, REDIRECT, HALTED. The state register and 3-bit counter are the only sequential state besides epc, cause and the target-select.
- accept = IDLE & id_valid & ~id_stall & (siic|rti|err|halt).
- Priority when several flags are set: halt > err > siic > rti. Only the winner acts.
- In IDLE with accept (cycle T), outputs are combinational:
  - flush_if_id = 1 in cycle T.
  - Trapping instruction itself proceeds with bubble = 0; its controls are inert.
- At the edge ending cycle T:
  - siic: epc <= id_pc_inc, cause <= 01, target-select <= SIIC_ADDR.
  - err: epc <= id_pc_inc, cause <= 10, target-select <= ERR_ADDR.
  - rti: epc and cause unchanged, target-select <= epc (value before the edge).
  - halt: cause <= 11.
  - All cases: state <= DRAIN, counter <= DRAIN_CYCLES-1.
- DRAIN:
  - Outputs: freeze = 1, bubble = 1, flush_if_id = 0, pc_redirect = 0.
  - Counter decrements each cycle.
  - At counter 0: go to HALTED if cause = 11 and the accepted event was halt, else go to REDIRECT.
  - Lasts exactly DRAIN_CYCLES cycles (T+1 .. T+DRAIN_CYCLES).
- REDIRECT (one cycle, T+DRAIN_CYCLES+1):
  - Outputs: pc_redirect = 1, pc_target = target-select, flush_if_id = 1, bubble = 1, freeze = 0.
  - Next state IDLE.
  - The first instruction at the target reaches ID at T+DRAIN_CYCLES+3.
- HALTED: terminal.
  - Outputs: halted = 1, freeze = 1, bubble = 1.
  - Leaves only via rst_n.
- busy = 1 in DRAIN, REDIRECT and HALTED.
- Inputs are ignored outside IDLE. Back-to-back traps are impossible during a sequence: fetch is frozen and ID is bubbled.
- id_stall = 1 blocks acceptance; the instruction re-presents later and is accepted then.
- id_valid = 0 blocks acceptance even if flags are set (flushed slot).
- RTI with no prior SIIC/err redirects to epc = 0.
- A second SIIC overwrites epc (no nesting stack).
- rst_n low mid-DRAIN or mid-REDIRECT aborts immediately to IDLE with all registers cleared. No redirect is issued after release.
- pc_target is 0 in every state except REDIRECT.

Test Plan:
1. Reset mid-sequence:
   - Stimulus: reset, then SIIC with id_pc_inc = 16'h0104, then rst_n low in the 2nd DRAIN cycle.
   - Required response: all outputs 0 and epc = 0 within the same cycle; no pc_redirect after release.
2. SIIC, default parameters:
   - Stimulus: SIIC with id_pc_inc = 16'h0104, id_valid = 1, id_stall = 0.
   - Required response: flush_if_id = 1 at T; freeze = bubble = 1 for T+1..T+3; pc_redirect = 1 with pc_target = 16'h0002 at T+4; epc = 16'h0104, cause = 01; IDLE at T+5.
3. SIIC then RTI:
   - Stimulus: the sequence of scenario 2, then RTI after return to IDLE.
   - Required response: same 3-cycle drain; pc_redirect with pc_target = 16'h0104; epc and cause unchanged.
4. Stall, then simultaneous flags:
   - Stimulus: err with id_stall = 1 for 2 cycles, then id_stall = 0; separately, halt and siic set together.
   - Required response: no action while stalled; accepted on the first unstalled cycle with cause = 10 and target 16'h0002. The halt + siic case goes to HALTED, epc unchanged, halted = 1 held for 20 cycles.
5. Invalid slot and DRAIN_CYCLES = 1:
   - Stimulus: siic = 1 with id_valid = 0; separately, DRAIN_CYCLES = 1 with an SIIC.
   - Required response: no flush and busy = 0 for the invalid slot. With DRAIN_CYCLES = 1, exactly one DRAIN cycle, with redirect at T+2.
